// File: rtl/key_press_detector_pkg.sv
// Shared definitions for the pushbutton front end: FSM state encoding and
// default timing for a 50 MHz system clock.
package key_press_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_press_detector_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reset value selects
// the level presented while rst_n is low.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_press_detector.sv
// Debounced pushbutton reader: clean level, press/release/long-press strobes
// and a wrapping press counter. One instance per key pin.
module key_press_detector
    import key_press_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    output logic             key_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic w_key_sync;
    logic w_pressed;

    key_state_t r_state;
    key_state_t w_state_nxt;

    logic [DB_W-1:0]   r_db_cnt,   w_db_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              r_long_done, w_long_done_nxt;
    logic              r_key_level, w_key_level_nxt;
    logic              r_press,     w_press_nxt;
    logic              r_release,   w_release_nxt;
    logic              r_long,      w_long_nxt;
    logic [CNT_W-1:0]  r_count,     w_count_nxt;

    // Synchronizer idles at the released pin level so reset never looks like a press.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (key_in),
        .o_q     (w_key_sync)
    );

    assign w_pressed = (w_key_sync != ACTIVE_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pressed) w_state_nxt = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!w_pressed)               w_state_nxt = ST_IDLE;
                else if (r_db_cnt == DB_LAST) w_state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!w_pressed) w_state_nxt = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (w_pressed)                w_state_nxt = ST_PRESSED;
                else if (r_db_cnt == DB_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Hold time keeps running through release bounces so long_pulse fires once per press.
    assign w_hold_inc = (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_comb begin
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_key_level_nxt = r_key_level;
        w_count_nxt     = r_count;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_db_cnt_nxt    = '0;
                w_key_level_nxt = 1'b0;
            end
            ST_PRESS_WAIT: begin
                if (w_pressed && r_db_cnt == DB_LAST) begin
                    w_press_nxt     = 1'b1;
                    w_key_level_nxt = 1'b1;
                    w_count_nxt     = r_count + 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_long_done_nxt = 1'b0;
                    w_db_cnt_nxt    = '0;
                end else if (w_pressed) begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end
            ST_PRESSED, ST_RELEASE_WAIT: begin
                w_hold_cnt_nxt = w_hold_inc;
                if (w_hold_inc == HOLD_LAST && !r_long_done) begin
                    w_long_nxt      = 1'b1;
                    w_long_done_nxt = 1'b1;
                end
                if (r_state == ST_PRESSED || w_pressed) begin
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_release_nxt   = 1'b1;
                    w_key_level_nxt = 1'b0;
                    w_db_cnt_nxt    = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_db_cnt_nxt    = '0;
                w_key_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_key_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_long_done <= w_long_done_nxt;
            r_key_level <= w_key_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign key_level     = r_key_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign press_count   = r_count;

endmodule

// File: tb/tb_key_press_detector.sv
// Bench for key_press_detector: run-length reference model checked every
// cycle, plus directed scenarios with hand-counted strobe timing.
module tb_key_press_detector;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b0;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    bit          done    = 1'b0;

    // Strobe tallies taken from the DUT for scenario-level expectations.
    int unsigned n_press = 0, n_rel = 0, n_long = 0;

    key_press_detector #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (1'b1),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: pressed is key_in delayed two edges; the accepted level flips once
    // the delayed input has disagreed with it on DEB+1 consecutive edges.
    // long_pulse fires LONG-1 edges after acceptance if the level is still held.
    bit          m_s1, m_s2, m_level;
    bit          m_press, m_rel, m_long;
    int unsigned m_run, m_cyc, m_acc;
    logic [7:0]  m_count;

    initial begin
        m_cyc = 0;
        m_acc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_count = '0;
                m_press = 0; m_rel = 0; m_long = 0;
            end else begin
                m_cyc++;
                m_press = 0; m_rel = 0; m_long = 0;
                if (m_level && (m_cyc - m_acc == LONG - 1)) m_long = 1;
                if (m_s2 != m_level) begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_level = !m_level;
                        m_run   = 0;
                        if (m_level) begin
                            m_press = 1;
                            m_count = m_count + 8'd1;
                            m_acc   = m_cyc;
                        end else begin
                            m_rel = 1;
                        end
                    end
                end else begin
                    m_run = 0;
                end
                m_s2 = m_s1;
                m_s1 = (key_in == 1'b0);
            end
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                check("key_level",     32'(key_level),     32'(m_level));
                check("press_pulse",   32'(press_pulse),   32'(m_press));
                check("release_pulse", 32'(release_pulse), 32'(m_rel));
                check("long_pulse",    32'(long_pulse),    32'(m_long));
                check("press_count",   32'(press_count),   32'(m_count));
                n_press += press_pulse;
                n_rel   += release_pulse;
                n_long  += long_pulse;
            end
        end
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return press_pulse;
            1:       return release_pulse;
            2:       return long_pulse;
            default: return key_level;
        endcase
    endfunction

    // Expect the selected strobe low for edges 1..n-1 and high right after edge n.
    task automatic expect_pulse(input int sel, input int unsigned n, input string name);
        logic        v;
        int unsigned early;
        v = 1'b0;
        early = 0;
        for (int unsigned i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            v = pick(sel);
            if (i < n && v) early++;
        end
        check({name, "_early"}, early, 0);
        check(name, 32'(v), 1);
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int unsigned p0, r0, l0;

    initial begin
        // 1: reset with key held, press detected at edge 7 after release of reset
        rst_n  = 1'b0;
        key_in = 1'b0;
        cycles(3);
        #1;
        check("rst_level", 32'(key_level), 0);
        check("rst_count", 32'(press_count), 0);
        check("rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_pulse(0, 7, "t1_press");
        check("t1_count", 32'(press_count), 1);
        @(negedge clk);
        key_in = 1'b1;
        expect_pulse(1, 7, "t1_release");
        cycles(4);

        // 2: short bounces never accepted
        p0 = n_press;
        for (int i = 0; i < 5; i++) begin
            key_in = 1'b0; cycles(3);
            key_in = 1'b1; cycles(3);
        end
        cycles(6);
        #1;
        check("t2_presses", n_press - p0, 0);
        check("t2_level", 32'(key_level), 0);
        check("t2_count", 32'(press_count), 1);

        // 3: clean tap, no long press
        @(negedge clk);
        l0 = n_long;
        key_in = 1'b0;
        expect_pulse(0, 7, "t3_press");
        cycles(3);
        key_in = 1'b1;
        expect_pulse(1, 7, "t3_release");
        cycles(4);
        #1;
        check("t3_long", n_long - l0, 0);
        check("t3_count", 32'(press_count), 2);

        // 4: long hold, long_pulse 19 edges after press_pulse
        @(negedge clk);
        l0 = n_long;
        key_in = 1'b0;
        expect_pulse(0, 7, "t4_press");
        expect_pulse(2, LONG - 1, "t4_long");
        cycles(14);
        key_in = 1'b1;
        expect_pulse(1, 7, "t4_release");
        cycles(4);
        #1;
        check("t4_long_once", n_long - l0, 1);

        // 5: release bounce while held
        @(negedge clk);
        l0 = n_long;
        r0 = n_rel;
        key_in = 1'b0;
        expect_pulse(0, 7, "t5_press");
        cycles(3);
        key_in = 1'b1; cycles(2);
        key_in = 1'b0; cycles(30);
        #1;
        check("t5_level", 32'(key_level), 1);
        check("t5_no_release", n_rel - r0, 0);
        check("t5_long_once", n_long - l0, 1);
        @(negedge clk);
        key_in = 1'b1;
        expect_pulse(1, 7, "t5_release");
        cycles(4);

        // 6a: counter wrap after 256 taps from reset
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        for (int i = 0; i < 256; i++) begin
            key_in = 1'b0; cycles(10);
            key_in = 1'b1; cycles(10);
            if (i == 254) begin
                #1;
                check("t6_count_255", 32'(press_count), 255);
            end
        end
        #1;
        check("t6_count_wrap", 32'(press_count), 0);

        // 6b: reset mid-hold drops outputs at once, then re-detects the press
        @(negedge clk);
        key_in = 1'b0;
        expect_pulse(0, 7, "t6_press");
        cycles(5);
        #1;
        check("t6_level_held", 32'(key_level), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_level", 32'(key_level), 0);
        check("t6_async_count", 32'(press_count), 0);
        cycles(2);
        rst_n = 1'b1;
        expect_pulse(0, 7, "t6_repress");
        check("t6_recount", 32'(press_count), 1);
        @(negedge clk);
        key_in = 1'b1;
        expect_pulse(1, 7, "t6_release");
        cycles(4);

        done = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
